// File: rtl/periph_bus_arbiter.sv
// Two-master peripheral bus arbiter: IDLE -> ACCESS (slave strobe) -> RESP (ready pulse), 2-cycle latency.
// Requesters wait on req until ready; `define ARB_ROUND_ROBIN_EN for alternating grants, else M0 has fixed priority.
module periph_bus_arbiter #(
  parameter int         N_SLAVES = 4,
  parameter logic [7:0] SLV_BASE = 8'h80
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m0_req_i,
  input  logic                  m0_we_i,
  input  logic [31:0]           m0_addr_i,
  input  logic [31:0]           m0_wdata_i,
  output logic [31:0]           m0_rdata_o,
  output logic                  m0_ready_o,
  input  logic                  m1_req_i,
  input  logic                  m1_we_i,
  input  logic [31:0]           m1_addr_i,
  input  logic [31:0]           m1_wdata_i,
  output logic [31:0]           m1_rdata_o,
  output logic                  m1_ready_o,
  output logic [N_SLAVES-1:0]   s_req_o,
  output logic                  s_we_o,
  output logic [31:0]           s_addr_o,
  output logic [31:0]           s_wdata_o,
  input  logic [32*N_SLAVES-1:0] s_rdata_i,
  output logic                  unmapped_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t              state_q;
  logic                grant_q;
  logic                we_q;
  logic                unmapped_q;
  logic [7:0]          sel_q;
  logic [N_SLAVES-1:0] s_req_q;
  logic                s_we_q;
  logic [31:0]         s_addr_q;
  logic [31:0]         s_wdata_q;
  logic [31:0]         m0_rdata_q;
  logic [31:0]         m1_rdata_q;
  logic                m0_ready_q;
  logic                m1_ready_q;
  logic                unmapped_o_q;
`ifdef ARB_ROUND_ROBIN_EN
  logic                last_q;
`endif

  logic                grant_d;
  logic                we_d;
  logic [31:0]         addr_d;
  logic [31:0]         wdata_d;
  logic [7:0]          sel_d;
  logic [N_SLAVES-1:0] dec_d;
  logic [31:0]         rdata_d;

  // grant_d is 1 when M1 wins; only consumed when at least one request is present
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    if (m0_req_i && m1_req_i) grant_d = ~last_q;
    else                      grant_d = ~m0_req_i;
`else
    grant_d = ~m0_req_i;
`endif
  end

  always_comb begin
    we_d    = grant_d ? m1_we_i    : m0_we_i;
    addr_d  = grant_d ? m1_addr_i  : m0_addr_i;
    wdata_d = grant_d ? m1_wdata_i : m0_wdata_i;
    sel_d   = addr_d[31:24] - SLV_BASE;
    dec_d   = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_d == 8'(i)) dec_d[i] = 1'b1;
    end
  end

  // Unmapped slots never match, so their read data falls out as zero
  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_q == 8'(i) && !we_q) rdata_d = s_rdata_i[32*i +: 32];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      we_q         <= 1'b0;
      unmapped_q   <= 1'b0;
      sel_q        <= '0;
      s_req_q      <= '0;
      s_we_q       <= 1'b0;
      s_addr_q     <= '0;
      s_wdata_q    <= '0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      m0_ready_q   <= 1'b0;
      m1_ready_q   <= 1'b0;
      unmapped_o_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q       <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_req_i || m1_req_i) begin
            state_q    <= ACCESS;
            grant_q    <= grant_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            unmapped_q <= (dec_d == '0);
            s_req_q    <= dec_d;
            s_we_q     <= we_d;
            s_addr_q   <= addr_d;
            s_wdata_q  <= wdata_d;
          end
        end
        ACCESS: begin
          state_q      <= RESP;
          s_req_q      <= '0;
          s_we_q       <= 1'b0;
          s_addr_q     <= '0;
          s_wdata_q    <= '0;
          m0_ready_q   <= ~grant_q;
          m1_ready_q   <= grant_q;
          m0_rdata_q   <= grant_q ? 32'h0 : rdata_d;
          m1_rdata_q   <= grant_q ? rdata_d : 32'h0;
          unmapped_o_q <= unmapped_q;
        end
        RESP: begin
          state_q      <= IDLE;
          m0_ready_q   <= 1'b0;
          m1_ready_q   <= 1'b0;
          m0_rdata_q   <= '0;
          m1_rdata_q   <= '0;
          unmapped_o_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
          last_q       <= grant_q;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_req_o    = s_req_q;
  assign s_we_o     = s_we_q;
  assign s_addr_o   = s_addr_q;
  assign s_wdata_o  = s_wdata_q;
  assign m0_rdata_o = m0_rdata_q;
  assign m1_rdata_o = m1_rdata_q;
  assign m0_ready_o = m0_ready_q;
  assign m1_ready_o = m1_ready_q;
  assign unmapped_o = unmapped_o_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Bench for periph_bus_arbiter: directed cases plus random two-master traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_periph_bus_arbiter;
  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [31:0]   m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          m0_ready, m1_ready;
  logic [NS-1:0] s_req;
  logic          s_we;
  logic [31:0]   s_addr, s_wdata;
  logic [32*NS-1:0] s_rdata;
  logic          unmapped;

  int total = 0;
  int bad   = 0;

  // Slave register file seen by the DUT, and the bench's own expectation of it
  logic [31:0] slv_mem [NS] = '{32'h0, 32'h1, 32'h2, 32'h3};
  logic [31:0] ref_mem [NS] = '{32'h0, 32'h1, 32'h2, 32'h3};
  int          last_m = 1;

  logic        t_we   [2][8];
  logic [31:0] t_addr [2][8];
  logic [31:0] t_data [2][8];
  int          n [2];

  always #5 clk = ~clk;

  periph_bus_arbiter #(.N_SLAVES(NS), .SLV_BASE(8'h80)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_rdata_o(m0_rdata), .m0_ready_o(m0_ready),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_rdata_o(m1_rdata), .m1_ready_o(m1_ready),
    .s_req_o(s_req), .s_we_o(s_we), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
    .s_rdata_i(s_rdata), .unmapped_o(unmapped)
  );

  always_comb begin
    s_rdata = '0;
    for (int i = 0; i < NS; i++) s_rdata[32*i +: 32] = slv_mem[i];
  end

  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (s_req[i] && s_we) slv_mem[i] <= s_wdata;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input int m, input int k);
    if (m == 0) begin
      m0_req   = (k < n[0]);
      m0_we    = (k < n[0]) ? t_we[0][k]   : 1'b0;
      m0_addr  = (k < n[0]) ? t_addr[0][k] : 32'h0;
      m0_wdata = (k < n[0]) ? t_data[0][k] : 32'h0;
    end else begin
      m1_req   = (k < n[1]);
      m1_we    = (k < n[1]) ? t_we[1][k]   : 1'b0;
      m1_addr  = (k < n[1]) ? t_addr[1][k] : 32'h0;
      m1_wdata = (k < n[1]) ? t_data[1][k] : 32'h0;
    end
  endtask

  // Both masters present their lists and hold req; each served transaction spans 3 clock edges
  task automatic run_seq();
    int          idx [2];
    int          g, k;
    bit          r0, r1, mapped, we;
    logic [7:0]  slot;
    logic [31:0] a, d, exp_rd;
    logic [NS-1:0] exp_req;
    idx[0] = 0;
    idx[1] = 0;
    present(0, 0);
    present(1, 0);
    while (idx[0] < n[0] || idx[1] < n[1]) begin
      r0 = (idx[0] < n[0]);
      r1 = (idx[1] < n[1]);
`ifdef ARB_ROUND_ROBIN_EN
      if (r0 && r1) g = (last_m == 1) ? 0 : 1;
      else          g = r0 ? 0 : 1;
`else
      g = r0 ? 0 : 1;
`endif
      k      = idx[g];
      we     = t_we[g][k];
      a      = t_addr[g][k];
      d      = t_data[g][k];
      slot   = a[31:24] - 8'h80;
      mapped = (slot < 8'(NS));
      for (int i = 0; i < NS; i++) exp_req[i] = mapped && (slot == 8'(i));

      tick();
      chk("access_s_req",   32'(s_req),   32'(exp_req));
      chk("access_s_we",    32'(s_we),    32'(we));
      chk("access_s_addr",  s_addr,       a);
      chk("access_s_wdata", s_wdata,      d);
      chk("access_ready",   32'({m0_ready, m1_ready}), 32'h0);

      exp_rd = 32'h0;
      for (int i = 0; i < NS; i++) begin
        if (mapped && slot == 8'(i)) begin
          if (!we) exp_rd = ref_mem[i];
          else     ref_mem[i] = d;
        end
      end

      tick();
      chk("resp_ready",    32'({m0_ready, m1_ready}), (g == 0) ? 32'h2 : 32'h1);
      chk("resp_rdata_g",  (g == 0) ? m0_rdata : m1_rdata, exp_rd);
      chk("resp_rdata_o",  (g == 0) ? m1_rdata : m0_rdata, 32'h0);
      chk("resp_unmapped", 32'(unmapped), 32'(!mapped));
      chk("resp_s_quiet",  32'({s_req, s_we}) | s_addr | s_wdata, 32'h0);

      last_m = g;
      idx[g]++;
      present(g, idx[g]);

      tick();
      chk("idle_quiet", 32'({m0_ready, m1_ready, unmapped, s_req, s_we}) | m0_rdata | m1_rdata, 32'h0);
    end
  endtask

  task automatic set_txn(input int m, input int k, input logic we, input logic [31:0] a, input logic [31:0] d);
    t_we[m][k]   = we;
    t_addr[m][k] = a;
    t_data[m][k] = d;
  endtask

  initial begin
    logic [7:0] top;
    int         r;
    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    tick(); tick(); tick();
    chk("rst_s_req",   32'(s_req), 32'h0);
    chk("rst_ready",   32'({m0_ready, m1_ready, unmapped, s_we}), 32'h0);
    chk("rst_rdata",   m0_rdata | m1_rdata | s_addr | s_wdata, 32'h0);
    rst = 1'b0;
    tick();

    // Write to LED slot from M0, M1 idle
    n[0] = 1; n[1] = 0;
    set_txn(0, 0, 1'b1, 32'h8000_0000, 32'h0000_A5A5);
    run_seq();
    chk("led_value", slv_mem[0], 32'h0000_A5A5);

    // M1 read of slot 1
    n[0] = 0; n[1] = 1;
    set_txn(1, 0, 1'b0, 32'h8100_0004, 32'h0);
    run_seq();

    // Write then read the same slot from M0
    n[0] = 2; n[1] = 0;
    set_txn(0, 0, 1'b1, 32'h8000_0010, 32'h1234_5678);
    set_txn(0, 1, 1'b0, 32'h8000_0010, 32'h0);
    run_seq();

    // Unmapped read
    n[0] = 1; n[1] = 0;
    set_txn(0, 0, 1'b0, 32'h9000_0000, 32'h0);
    run_seq();

    // Both masters contend for four transactions each
    n[0] = 4; n[1] = 4;
    for (int k = 0; k < 4; k++) begin
      set_txn(0, k, 1'b1, 32'h8200_0000 + 32'(k), 32'hC0DE_0000 + 32'(k));
      set_txn(1, k, 1'b0, 32'h8200_0000, 32'h0);
    end
    run_seq();

    // Reset while a read is in ACCESS: no ready, then re-arbitrated after release
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h8300_0000; m0_wdata = 32'h0;
    tick();
    chk("rst_mid_strobe", 32'(s_req), 32'h8);
    rst = 1'b1;
    tick();
    chk("rst_mid_quiet", 32'({m0_ready, m1_ready, unmapped, s_req, s_we}) | s_addr | m0_rdata, 32'h0);
    rst = 1'b0;
    last_m = 1;
    tick();
    chk("rst_retry_strobe", 32'(s_req), 32'h8);
    tick();
    chk("rst_retry_ready", 32'(m0_ready), 32'h1);
    chk("rst_retry_rdata", m0_rdata, ref_mem[3]);
    last_m = 0;
    m0_req = 1'b0;
    tick();

    // Granted master drops req during ACCESS; transaction still completes
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h8200_0000;
    tick();
    chk("drop_strobe", 32'(s_req), 32'h4);
    m0_req = 1'b0;
    tick();
    chk("drop_ready", 32'(m0_ready), 32'h1);
    chk("drop_rdata", m0_rdata, ref_mem[2]);
    last_m = 0;
    tick();

    // Random contention with mapped and unmapped addresses
    for (int it = 0; it < 25; it++) begin
      n[0] = $urandom_range(0, 3);
      n[1] = $urandom_range((n[0] == 0) ? 1 : 0, 3);
      for (int m = 0; m < 2; m++) begin
        for (int k = 0; k < 4; k++) begin
          r   = $urandom_range(0, 6);
          top = (r == 6) ? 8'h7F : 8'h80 + 8'(r);
          set_txn(m, k, 1'($urandom_range(0, 1)), {top, 24'($urandom)}, $urandom);
        end
      end
      run_seq();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
